// File: rtl/pulse_qualifier_mc_if.sv
// Pulse qualifier bus: per-channel pulse inputs, shared config, and
// per-channel strobes/widths. master = stimulus side, slave = qualifier.
interface pulse_qualifier_mc_if #(
  parameter int CH = 4,
  parameter int CW = 8
);
  logic [CH-1:0]    signal;
  logic             mode;
  logic [CW-1:0]    min_len;
  logic [CW-1:0]    max_len;
  logic [CH-1:0]    valid;
  logic [CH-1:0]    short_err;
  logic [CH-1:0]    long_err;
  logic [CH*CW-1:0] width_out;

  modport master (
    output signal, mode, min_len, max_len,
    input  valid, short_err, long_err, width_out
  );

  modport slave (
    input  signal, mode, min_len, max_len,
    output valid, short_err, long_err, width_out
  );
endinterface

// File: rtl/pulse_qualifier_mc.sv
// Multi-channel pulse-width qualifier (EARLY / WINDOW modes).
// Ports: clk, rst (sync, active high); bus (slave): signal, mode,
// min_len, max_len in; valid, short_err, long_err, width_out out.
module pulse_qualifier_mc #(
  parameter int CH = 4,
  parameter int CW = 8
) (
  input logic                 clk,
  input logic                 rst,
  pulse_qualifier_mc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    LOCK = 2'd2
  } st_e;

  localparam logic [CW-1:0] ONES = '1;
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] min_in;
  logic [CH-1:0] valid_v;
  logic [CH-1:0] serr_v;
  logic [CH-1:0] lerr_v;

  // A zero minimum means "any pulse qualifies", i.e. one sample.
  assign min_in = (bus.min_len == '0) ? ONE : bus.min_len;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    st_e           st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] min_q, min_d;
    logic [CW-1:0] max_q, max_d;
    logic          vld_q, vld_d;
    logic          se_q, se_d;
    logic          le_q, le_d;
    logic [CW-1:0] wid_q, wid_d;
    logic [CW-1:0] inc;
    logic          sig;

    assign sig = bus.signal[i];
    assign inc = (cnt_q == ONES) ? cnt_q : cnt_q + ONE;

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        prev_q <= 1'b1;
        mode_q <= 1'b0;
        min_q  <= '0;
        max_q  <= '0;
        vld_q  <= 1'b0;
        se_q   <= 1'b0;
        le_q   <= 1'b0;
        wid_q  <= '0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        prev_q <= prev_d;
        mode_q <= mode_d;
        min_q  <= min_d;
        max_q  <= max_d;
        vld_q  <= vld_d;
        se_q   <= se_d;
        le_q   <= le_d;
        wid_q  <= wid_d;
      end
    end

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      prev_d = sig;
      mode_d = mode_q;
      min_d  = min_q;
      max_d  = max_q;
      vld_d  = 1'b0;
      se_d   = 1'b0;
      le_d   = 1'b0;
      wid_d  = wid_q;
      unique case (st_q)
        IDLE: begin
          if (sig && !prev_q) begin
            cnt_d  = ONE;
            mode_d = bus.mode;
            min_d  = min_in;
            max_d  = bus.max_len;
            st_d   = MEAS;
            if (!bus.mode && min_in == ONE) begin
              vld_d = 1'b1;
              wid_d = ONE;
            end
          end
        end
        MEAS: begin
          if (sig) begin
            cnt_d = inc;
            if (!mode_q) begin
              // Saturated count must not re-hit min.
              if (cnt_q != ONES && inc == min_q) begin
                vld_d = 1'b1;
                wid_d = min_q;
              end
            end else if (max_q != ONES && cnt_q >= max_q) begin
              le_d = 1'b1;
              st_d = LOCK;
            end
          end else begin
            st_d = IDLE;
            if (mode_q) begin
              if (cnt_q < min_q) begin
                se_d = 1'b1;
              end else if (cnt_q <= max_q) begin
                vld_d = 1'b1;
                wid_d = cnt_q;
              end
            end
          end
        end
        LOCK: begin
          if (!sig) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end

    assign valid_v[i] = vld_q;
    assign serr_v[i]  = se_q;
    assign lerr_v[i]  = le_q;
    assign bus.width_out[i*CW +: CW] = wid_q;
  end

  assign bus.valid     = valid_v;
  assign bus.short_err = serr_v;
  assign bus.long_err  = lerr_v;

endmodule

// File: doc/pulse_qualifier_mc.md
# pulse_qualifier_mc

Multi-channel pulse-width qualifier. Each of `CH` asynchronous-origin, already-synchronised input lines is measured independently, and each channel emits single-cycle qualification strobes. Two modes are selectable:

- **EARLY**: fire once when a pulse reaches `min_len`.
- **WINDOW**: judge the complete pulse against `[min_len, max_len]` at its falling edge and report the measured width.

The block sits between input synchronisers and the event/interrupt logic. It replaces single-channel fixed-length noise filters.

## Interface

- `CH`, 4: number of independent channels.
- `CW`, 8: width of the length counter and of the `min_len`/`max_len`/width fields.

- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `signal` input CH: per-channel pulse inputs, sampled each `clk`.
- `mode` input 1: 0 = EARLY, 1 = WINDOW; latched per channel at pulse start.
- `min_len` input CW: minimum accepted length in high samples; 0 is treated as 1; latched at pulse start.
- `max_len` input CW: maximum accepted length (WINDOW only); all-ones = no upper limit; latched at pulse start.
- `valid` output CH: one-cycle strobe per channel, pulse accepted.
- `short_err` output CH: one-cycle strobe, pulse ended below `min_len` (WINDOW only).
- `long_err` output CH: one-cycle strobe, pulse exceeded `max_len` (WINDOW only).
- `width_out` output CH*CW: channel i at bits [i*CW +: CW]; width of the last accepted pulse, held until the next `valid` on that channel.

## Operation

Per-channel registers:
- `prev`
- `cnt` (CW bits, saturating at all-ones)
- latched `mode`, `min_len`, `max_len`
- 2-bit state

States:
- **IDLE**
  - On `signal & ~prev`: `cnt<=1`, latch config, go to MEAS.
  - A level that is already high, without a preceding low sample, never starts a pulse.
- **MEAS**, `signal` high: `cnt<=cnt+1`, saturating.
  - EARLY: when the new count equals `min_len`, `valid<=1` and `width_out<=min_len`. This fires at most once per pulse. With `min_len` ≤ 1 it fires on the rising-edge sample itself, from IDLE.
  - WINDOW with `max_len` ≠ all-ones: when the new count would be `max_len+1`, `long_err<=1` and go to LOCKOUT.
- **MEAS**, `signal` low: L = `cnt`, go to IDLE.
  - WINDOW, `min_len` ≤ L ≤ `max_len`: `valid<=1`, `width_out<=L`.
  - WINDOW, L < `min_len`: `short_err<=1`.
  - EARLY: no strobe at the falling edge. A pulse shorter than `min_len` is silently dropped.
- **LOCKOUT**: wait for `signal` low, then go to IDLE. No strobes. The count does not matter.

General rules:
- `prev<=signal` every cycle.
- Strobes default to 0 every cycle. At most one of `valid`/`short_err`/`long_err` is set per channel per cycle.
- Channels share no state except the config inputs. Simultaneous events on different channels are independent.
- WINDOW with `max_len < min_len`: no pulse can be accepted. Every pulse ends in `short_err` or `long_err`.
- EARLY ignores `max_len`. A counter saturated at all-ones stays saturated until the falling edge.
- Config changes mid-pulse have no effect until the next pulse start.

## Timing

- **Reset values:** state IDLE, `cnt` 0, `prev` 1 (so a line high out of reset is not an edge), latched config 0, all strobes 0, `width_out` 0.
- **Reset mid-pulse:** the pulse is abandoned and no strobe is issued. Because `prev` is 1, the line must go low and then high again to start a new pulse.
- **Sample numbering:** the rising-edge sample is high sample 1.
- **EARLY latency:** `valid` is registered on the edge that samples high sample number `min_len`, so it is visible in the following cycle.
- **WINDOW accept/short latency:** `valid` or `short_err` is registered on the edge that samples the first low. It is one cycle wide.
- **WINDOW long latency:** `long_err` is registered on the edge sampling high sample `max_len+1`.
- **Back-to-back pulses:** a single low sample between pulses is sufficient. The edge that samples low sets `prev=0`, so the next high sample is a new rising edge. The end strobe of one pulse and the start of the next on the same channel never collide.
- **Throughput:** one pulse per channel per 2 cycles minimum. No backpressure.

## Test plan

- **EARLY, min_len=6:** ch0 high for 10 samples → `valid[0]` one cycle at high sample 6, `width_out[0]`=6, no further strobes. High for 5 samples → no strobe.
- **WINDOW, min=3, max=8:**
  - ch1 high 3 → `valid`, width 3.
  - high 8 → `valid`, width 8.
  - high 2 → `short_err[1]` on the falling sample.
  - high 12 → `long_err[1]` at high sample 9, then silence until low.
- **Simultaneous channels:** WINDOW min=2 max=4; ch0 high 3 and ch2 high 5 at the same time → `valid[0]` (width 3) and `long_err[2]` at their respective edges. ch1/ch3 stay quiet.
- **Reset:** hold `signal`=all-ones through `rst` release → no strobes until a low-then-high. Assert `rst` mid-pulse at count 4 (EARLY, min=6) → no `valid`, `width_out` returns to 0.
- **Config latching and boundaries:**
  - Switch `mode` 0→1 and `min_len` 6→2 mid-pulse → the pulse is still judged as EARLY with min 6.
  - `min_len`=0 → behaves as 1.
  - `max_len`=255 with a 300-sample pulse → `valid`, `width_out`=255.
  - 1-cycle low gap between two 4-sample pulses → two `valid` strobes.
